// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC result writer.
package mac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StWrite,
        StDone
    } state_t;

    localparam int unsigned DEFAULT_M          = 2;
    localparam int unsigned DEFAULT_K          = 2;
    localparam int unsigned DEFAULT_N          = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Product width plus enough headroom to sum K products without wrapping.
    function automatic int unsigned result_width(input int unsigned data_width,
                                                 input int unsigned k);
        return 2 * data_width + $clog2(k);
    endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// Accumulator register with its adder; clear takes priority over load.
module mac_acc_lane #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] acc_q;

    assign sum = acc_q + addend;
    assign acc = acc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mac_result_writer.sv
// Accumulates tagged A*B products into C elements and writes them row-major.
// Optional RESULT_PARITY_EN adds a result_parity output (XOR of wr_data).
module mac_result_writer
    import mac_pkg::*;
#(
    parameter int unsigned M                        = DEFAULT_M,
    parameter int unsigned K                        = DEFAULT_K,
    parameter int unsigned N                        = DEFAULT_N,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX   = DEFAULT_DATA_WIDTH,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic                                prod_valid,
    output logic                                prod_ready,
    input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] prod_data,
    input  logic [$clog2(M)-1:0]                prod_row,
    input  logic [$clog2(N)-1:0]                prod_col,
    input  logic [$clog2(K)-1:0]                prod_k,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [$clog2(M)-1:0]                wr_row_addr,
    output logic [$clog2(N)-1:0]                wr_col_addr,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] wr_data,
    output logic                                busy,
    output logic                                done,
    output logic                                err
`ifdef RESULT_PARITY_EN
    ,
    output logic                                result_parity
`endif
);

    localparam int unsigned RW = $clog2(M);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned KW = $clog2(K);
    localparam int unsigned DW = DATA_WIDTH_RESULT_MATRIX;

    localparam logic [RW-1:0] M_LAST = RW'(M - 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic            err_q, err_d;
    logic [RW-1:0]   wr_row_q, wr_row_d;
    logic [CW-1:0]   wr_col_q, wr_col_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic            acc_clear;
    logic            acc_load;
    logic [DW-1:0]   acc_value;
    logic [DW-1:0]   acc_sum;

    mac_acc_lane #(
        .WIDTH (DW)
    ) u_acc_lane (
        .clk    (clk),
        .resetn (resetn),
        .clear  (acc_clear),
        .load   (acc_load),
        .addend (DW'(prod_data)),
        .acc    (acc_value),
        .sum    (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        err_d     = err_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAccum;
                    acc_clear = 1'b1;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    err_d     = 1'b0;
                end
            end
            StAccum: begin
                if (prod_valid) begin
                    acc_load = 1'b1;
                    // Mis-tagged products still count; only the flag records it.
                    if (prod_row != i_q || prod_col != j_q || prod_k != k_q) begin
                        err_d = 1'b1;
                    end
                    if (k_q == K_LAST) begin
                        wr_data_d = acc_sum;
                        wr_row_d  = i_q;
                        wr_col_d  = j_q;
                        acc_clear = 1'b1;
                        k_d       = '0;
                        state_d   = StWrite;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                if (wr_ready) begin
                    if (i_q == M_LAST && j_q == N_LAST) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StAccum;
                        if (j_q == N_LAST) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            err_q     <= err_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign prod_ready  = (state_q == StAccum);
    assign wr_valid    = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err         = err_q;
    assign wr_row_addr = wr_row_q;
    assign wr_col_addr = wr_col_q;
    assign wr_data     = wr_data_q;

`ifdef RESULT_PARITY_EN
    assign result_parity = wr_valid & (^wr_data_q);
`endif

endmodule

// File: tb/tb_mac_result_writer.sv
// Directed table-driven bench for mac_result_writer (2x2x2, 32-bit elements).
module tb_mac_result_writer;

    localparam int unsigned M   = 2;
    localparam int unsigned K   = 2;
    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned RES = 65;

    logic           clk;
    logic           resetn;
    logic           start;
    logic           prod_valid;
    logic           prod_ready;
    logic [63:0]    prod_data;
    logic [0:0]     prod_row;
    logic [0:0]     prod_col;
    logic [0:0]     prod_k;
    logic           wr_valid;
    logic           wr_ready;
    logic [0:0]     wr_row_addr;
    logic [0:0]     wr_col_addr;
    logic [RES-1:0] wr_data;
    logic           busy;
    logic           done;
    logic           err;
`ifdef RESULT_PARITY_EN
    logic           result_parity;
`endif

    mac_result_writer #(
        .M                        (M),
        .K                        (K),
        .N                        (N),
        .DATA_WIDTH_INIT_MATRIX   (DW),
        .DATA_WIDTH_RESULT_MATRIX (RES)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .prod_data   (prod_data),
        .prod_row    (prod_row),
        .prod_col    (prod_col),
        .prod_k      (prod_k),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row_addr (wr_row_addr),
        .wr_col_addr (wr_col_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef RESULT_PARITY_EN
        ,
        .result_parity (result_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]    p0;
        logic [63:0]    p1;
        logic [RES-1:0] exp;
        int             stall;
        bit             bad_k;
    } vec_t;

    vec_t vecs[12];
    int   pass_cnt;
    int   total_cnt;

    task automatic chk(input string name, input logic [RES-1:0] act, input logic [RES-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".prod_ready"}, RES'(prod_ready), '0);
        chk({tag, ".wr_valid"}, RES'(wr_valid), '0);
        chk({tag, ".wr_row_addr"}, RES'(wr_row_addr), '0);
        chk({tag, ".wr_col_addr"}, RES'(wr_col_addr), '0);
        chk({tag, ".wr_data"}, wr_data, '0);
        chk({tag, ".busy"}, RES'(busy), '0);
        chk({tag, ".done"}, RES'(done), '0);
        chk({tag, ".err"}, RES'(err), '0);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic start_pass();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.busy", RES'(busy), 1);
        chk("start.prod_ready", RES'(prod_ready), 1);
        chk("start.err_cleared", RES'(err), 0);
    endtask

    task automatic send(input logic [63:0] d, input int r, input int c, input int k);
        int n;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_row   = 1'(r);
        prod_col   = 1'(c);
        prod_k     = 1'(k);
        n = 0;
        while (!prod_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!prod_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: prod_ready stayed 0, required 1 at %0t", $time);
        end
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic expect_write(input int r, input int c, input logic [RES-1:0] exp,
                                input int stall, input bit last);
        chk("wr.valid_latency1", RES'(wr_valid), 1);
        chk("wr.row", RES'(wr_row_addr), RES'(r));
        chk("wr.col", RES'(wr_col_addr), RES'(c));
        chk("wr.data", wr_data, exp);
        chk("wr.prod_ready_low", RES'(prod_ready), 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall.wr_valid", RES'(wr_valid), 1);
            chk("stall.row", RES'(wr_row_addr), RES'(r));
            chk("stall.col", RES'(wr_col_addr), RES'(c));
            chk("stall.data", wr_data, exp);
            chk("stall.prod_ready", RES'(prod_ready), 0);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        chk("post_wr.wr_valid", RES'(wr_valid), 0);
        chk("post_wr.done", RES'(done), last ? 1 : 0);
        chk("post_wr.prod_ready", RES'(prod_ready), last ? 0 : 1);
    endtask

    task automatic run_pass(input int base, input bit exp_err);
        vec_t v;
        start_pass();
        for (int e = 0; e < 4; e++) begin
            v = vecs[base + e];
            send(v.p0, e / 2, e % 2, 0);
            send(v.p1, e / 2, e % 2, v.bad_k ? 0 : 1);
            expect_write(e / 2, e % 2, v.exp, v.stall, e == 3);
        end
        chk("done.busy", RES'(busy), 1);
        chk("done.err", RES'(err), RES'(exp_err));
        @(negedge clk);
        chk("after_done.done", RES'(done), 0);
        chk("after_done.busy", RES'(busy), 0);
        chk("after_done.err", RES'(err), RES'(exp_err));
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_row   = '0;
        prod_col   = '0;
        prod_k     = '0;
        wr_ready   = 1'b0;

        // A=[[1,2],[3,4]], B=[[5,6],[7,8]]: products per C element, one stalled write.
        vecs[0]  = '{p0: 64'd5,  p1: 64'd14, exp: 65'd19, stall: 0, bad_k: 1'b0};
        vecs[1]  = '{p0: 64'd6,  p1: 64'd16, exp: 65'd22, stall: 3, bad_k: 1'b0};
        vecs[2]  = '{p0: 64'd15, p1: 64'd28, exp: 65'd43, stall: 0, bad_k: 1'b0};
        vecs[3]  = '{p0: 64'd18, p1: 64'd32, exp: 65'd50, stall: 1, bad_k: 1'b0};
        // Maximum products: sum needs the 65th bit.
        for (int e = 4; e < 8; e++) begin
            vecs[e] = '{p0: 64'hFFFF_FFFE_0000_0001, p1: 64'hFFFF_FFFE_0000_0001,
                        exp: 65'h1_FFFF_FFFC_0000_0002, stall: 0, bad_k: 1'b0};
        end
        // Same as the first pass but C(0,0)'s second product is tagged k=0.
        for (int e = 8; e < 12; e++) vecs[e] = vecs[e - 8];
        vecs[8].bad_k = 1'b1;
        vecs[9].stall = 0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("idle.busy", RES'(busy), 0);
        prod_valid = 1'b1;
        @(negedge clk);
        chk("idle.prod_ready", RES'(prod_ready), 0);
        prod_valid = 1'b0;

        run_pass(0, 1'b0);
        run_pass(4, 1'b0);
        run_pass(8, 1'b1);
        run_pass(0, 1'b0);

        // Reset after three products, one write already done.
        start_pass();
        send(64'd5, 0, 0, 0);
        send(64'd14, 0, 0, 1);
        expect_write(0, 0, 65'd19, 0, 1'b0);
        send(64'd6, 0, 1, 0);
        #1;
        resetn = 1'b0;
        #1;
        chk_all_zero("midpass_reset");
        wr_ready   = 1'b1;
        prod_valid = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_write_after_reset", RES'(wr_valid), 0);
            chk("no_restart_without_start", RES'(busy), 0);
        end
        wr_ready   = 1'b0;
        prod_valid = 1'b0;
        run_pass(0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
